// File: rtl/cu_pkg.sv
// Shared types for the ProjectB control unit: state and opcode encodings,
// ALU select codes and the instruction field positions.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Bit positions within the 16-bit instruction word.
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int ADDR_HI = 11;
    localparam int ADDR_LO = 4;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 8;
    localparam int RB_HI   = 7;
    localparam int RB_LO   = 4;
    localparam int REG_HI  = 3;
    localparam int REG_LO  = 0;

    // Unassigned opcodes behave as NOOP.
    function automatic opcode_t decode_opcode(input logic [3:0] raw);
        case (raw)
            4'd1:    return OP_STORE;
            4'd2:    return OP_LOAD;
            4'd3:    return OP_ADD;
            4'd4:    return OP_SUB;
            4'd5:    return OP_HALT;
            default: return OP_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit and the ProjectB datapath:
// instruction in, PC/IR/register-file/ALU/memory strobes out.
interface control_unit_if #(
    parameter int INSTR_W  = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
);
    logic [INSTR_W-1:0]  ir;
    logic                pc_clr;
    logic                pc_up;
    logic                ir_ld;
    logic [D_ADDR_W-1:0] d_addr;
    logic                d_wr;
    logic                rf_s;
    logic [R_ADDR_W-1:0] rf_w_addr;
    logic                rf_w_en;
    logic [R_ADDR_W-1:0] rf_ra_addr;
    logic [R_ADDR_W-1:0] rf_rb_addr;
    logic [2:0]          alu_s0;
    logic [3:0]          state_out;

    modport master (
        input  ir,
        output pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr,
               rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, state_out
    );

    modport slave (
        output ir,
        input  pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr,
               rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, state_out
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational output decode: maps the current state and the instruction
// operand fields to every datapath strobe. Optional: CU_SINGLE_STEP_EN.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  state_t              state,
    input  logic [INSTR_W-5:0]  operand,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                pc_clr,
    output logic                pc_up,
    output logic                ir_ld,
    output logic [D_ADDR_W-1:0] d_addr,
    output logic                d_wr,
    output logic                rf_s,
    output logic [R_ADDR_W-1:0] rf_w_addr,
    output logic                rf_w_en,
    output logic [R_ADDR_W-1:0] rf_ra_addr,
    output logic [R_ADDR_W-1:0] rf_rb_addr,
    output logic [2:0]          alu_s0,
    output logic [3:0]          state_out
);

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_PASS;
        state_out  = state;

        case (state)
            ST_INIT: pc_clr = 1'b1;
            ST_FETCH: begin
`ifdef CU_SINGLE_STEP_EN
                // A stalled fetch must not advance the PC or clobber the IR.
                pc_up = step;
                ir_ld = step;
`else
                pc_up = 1'b1;
                ir_ld = 1'b1;
`endif
            end
            ST_LOAD_A, ST_LOAD_B: begin
                d_addr    = operand[ADDR_HI:ADDR_LO];
                rf_s      = 1'b1;
                rf_w_addr = operand[REG_HI:REG_LO];
                // Write back only once the synchronous memory read has landed.
                rf_w_en   = (state == ST_LOAD_B);
            end
            ST_STORE: begin
                d_addr     = operand[ADDR_HI:ADDR_LO];
                rf_ra_addr = operand[REG_HI:REG_LO];
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = operand[RA_HI:RA_LO];
                rf_rb_addr = operand[RB_HI:RB_LO];
                rf_w_addr  = operand[REG_HI:REG_LO];
                alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
                rf_w_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ProjectB control FSM: state register and next-state logic; output decode
// lives in cu_decoder. Optional macro CU_SINGLE_STEP_EN adds a step input.
module control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    control_unit_if.master  bus
);

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state <= ST_FETCH;
`ifdef CU_SINGLE_STEP_EN
                ST_FETCH:  if (step) state <= ST_DECODE;
`else
                ST_FETCH:  state <= ST_DECODE;
`endif
                ST_DECODE: begin
                    case (decode_opcode(bus.ir[OP_HI:OP_LO]))
                        OP_LOAD:  state <= ST_LOAD_A;
                        OP_STORE: state <= ST_STORE;
                        OP_ADD:   state <= ST_ADD;
                        OP_SUB:   state <= ST_SUB;
                        OP_HALT:  state <= ST_HALT;
                        default:  state <= ST_NOOP;
                    endcase
                end
                ST_LOAD_A: state <= ST_LOAD_B;
                ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB:
                           state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                // Unused encodings restart cleanly.
                default:   state <= ST_INIT;
            endcase
        end
    end

    cu_decoder #(
        .INSTR_W  (INSTR_W),
        .D_ADDR_W (D_ADDR_W),
        .R_ADDR_W (R_ADDR_W)
    ) u_decoder (
        .state      (state),
        .operand    (bus.ir[INSTR_W-5:0]),
`ifdef CU_SINGLE_STEP_EN
        .step       (step),
`endif
        .pc_clr     (bus.pc_clr),
        .pc_up      (bus.pc_up),
        .ir_ld      (bus.ir_ld),
        .d_addr     (bus.d_addr),
        .d_wr       (bus.d_wr),
        .rf_s       (bus.rf_s),
        .rf_w_addr  (bus.rf_w_addr),
        .rf_w_en    (bus.rf_w_en),
        .rf_ra_addr (bus.rf_ra_addr),
        .rf_rb_addr (bus.rf_rb_addr),
        .alu_s0     (bus.alu_s0),
        .state_out  (bus.state_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions plus random programs checked
// cycle by cycle against a per-instruction timing model.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rw;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        step;
    logic [15:0] ir;
    int          n_tests;
    int          n_fail;

    control_unit_if #(.INSTR_W(16), .D_ADDR_W(8), .R_ADDR_W(4)) bus ();
    assign bus.ir = ir;

    control_unit #(.INSTR_W(16), .D_ADDR_W(8), .R_ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.st     = bus.state_out;
        o.pc_clr = bus.pc_clr;
        o.pc_up  = bus.pc_up;
        o.ir_ld  = bus.ir_ld;
        o.d_addr = bus.d_addr;
        o.d_wr   = bus.d_wr;
        o.rf_s   = bus.rf_s;
        o.rw     = bus.rf_w_addr;
        o.w_en   = bus.rf_w_en;
        o.ra     = bus.rf_ra_addr;
        o.rb     = bus.rf_rb_addr;
        o.alu    = bus.alu_s0;
        return o;
    endfunction

    // Cycles an instruction occupies, FETCH included.
    function automatic int model_len(input logic [15:0] ins);
        return (ins[15:12] == 4'h2) ? 4 : 3;
    endfunction

    // Expected bus contents in cycle k of an instruction (k=0 is FETCH).
    function automatic obs_t model_cycle(input logic [15:0] ins, input int k);
        obs_t o;
        o = '0;
        if (k == 0) begin
            o.st = 4'd1; o.pc_up = 1'b1; o.ir_ld = 1'b1;
        end else if (k == 1) begin
            o.st = 4'd2;
        end else begin
            case (ins[15:12])
                4'h1: begin
                    o.st = 4'd6; o.d_addr = ins[11:4]; o.ra = ins[3:0]; o.d_wr = 1'b1;
                end
                4'h2: begin
                    o.st = (k == 2) ? 4'd4 : 4'd5;
                    o.d_addr = ins[11:4]; o.rf_s = 1'b1; o.rw = ins[3:0];
                    o.w_en = (k == 3);
                end
                4'h3, 4'h4: begin
                    o.st  = (ins[15:12] == 4'h3) ? 4'd7 : 4'd8;
                    o.alu = (ins[15:12] == 4'h3) ? 3'b001 : 3'b010;
                    o.ra = ins[11:8]; o.rb = ins[7:4]; o.rw = ins[3:0]; o.w_en = 1'b1;
                end
                4'h5:    o.st = 4'd9;
                default: o.st = 4'd3;
            endcase
        end
        return o;
    endfunction

    // Entered just after the edge that starts a FETCH cycle; leaves just after
    // the edge that starts the following FETCH (or HALT persists).
    // abort_at >= 0 asserts reset after that cycle and checks the INIT cycle.
    task automatic run_instr(input string tag, input logic [15:0] ins, input int abort_at);
        obs_t o;
        obs_t e;
        int   len;
        len = model_len(ins);
`ifdef CU_SINGLE_STEP_EN
        begin
            int stalls;
            stalls = $urandom_range(0, 3);
            step = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                e = '0;
                e.st = 4'd1;
                @(negedge clk);
                o = sample();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s step_stall %0d: got %h required %h", tag, s, o, e);
                end
                @(posedge clk); #1;
            end
            step = 1'b1;
        end
`endif
        for (int k = 0; k < len; k++) begin
            e = model_cycle(ins, k);
            @(negedge clk);
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d ir=%h: got %h required %h", tag, k, ins, o, e);
            end
            n_tests++;
            if (o.d_wr && o.w_en) begin
                n_fail++;
                $display("FAIL %s excl_write cycle %0d: got d_wr=%b rf_w_en=%b required not both", tag, k, o.d_wr, o.w_en);
            end
            n_tests++;
            if (o.pc_clr && o.pc_up) begin
                n_fail++;
                $display("FAIL %s excl_pc cycle %0d: got pc_clr=%b pc_up=%b required not both", tag, k, o.pc_clr, o.pc_up);
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                e = '0;
                e.pc_clr = 1'b1;
                @(negedge clk);
                o = sample();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s abort_init after cycle %0d: got %h required %h", tag, k, o, e);
                end
                reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (k == 0) ir = ins;
`ifdef CU_SINGLE_STEP_EN
            // Step pulses outside FETCH must have no effect.
            step = 1'($urandom_range(0, 1));
`endif
        end
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        e = '0;
        e.pc_clr = 1'b1;
        @(negedge clk);
        o = sample();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_init: got %h required %h", o, e);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        run_instr("load", 16'h2A35, -1);
    endtask

    task automatic test_store();
        run_instr("store", 16'h10F2, -1);
    endtask

    task automatic test_alu();
        run_instr("add", 16'h3123, -1);
        run_instr("sub", 16'h4123, -1);
    endtask

    task automatic test_halt();
        obs_t o;
        obs_t e;
        run_instr("halt", 16'h5000, -1);
        e = '0;
        e.st = 4'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt_hold %0d: got %h required %h", i, o, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        e = '0;
        e.pc_clr = 1'b1;
        @(negedge clk);
        o = sample();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL halt_reset: got %h required %h", o, e);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_instr("illegal_noop", 16'hF000, -1);
    endtask

    task automatic test_reset_mid_load();
        run_instr("reset_in_load_a", 16'h2A35, 2);
        run_instr("after_abort", 16'h3456, -1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins;
        int          abort;
        for (int i = 0; i < 250; i++) begin
            ins = 16'($urandom_range(0, 65535));
            if (ins[15:12] == 4'h5) ins[15:12] = 4'h2;
            abort = ($urandom_range(0, 15) == 0) ? $urandom_range(0, model_len(ins) - 1) : -1;
            run_instr("random", ins, abort);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        step    = 1'b0;
        ir      = 16'h0000;
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_halt();
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
